// File: rtl/adc_stream_tx_pkg.sv
// Shared constants and types for the ADC sample stream transmitter.
// ADC_STREAM_TX_PRBS_EN selects the LFSR generator for mode 3; otherwise mode 3 is a ramp.
package adc_stream_tx_pkg;

  localparam int unsigned PRBS_W = 8;

  typedef enum logic [1:0] {
    MODE_RAMP  = 2'd0,
    MODE_TRI   = 2'd1,
    MODE_CONST = 2'd2,
    MODE_PRBS  = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  // x^8+x^6+x^5+x^4+1, Fibonacci form shifting towards the MSB
  localparam logic [PRBS_W-1:0] PRBS_SEED = 8'hFF;
  localparam logic [PRBS_W-1:0] PRBS_TAPS = 8'hB8;

  function automatic logic [PRBS_W-1:0] prbs_next(input logic [PRBS_W-1:0] s);
    return {s[PRBS_W-2:0], ^(s & PRBS_TAPS)};
  endfunction

endpackage

// File: rtl/adc_tx_lfsr8.sv
// 8-bit PRBS generator with seed load and advance enable.
// Only built when ADC_STREAM_TX_PRBS_EN is defined.
`ifdef ADC_STREAM_TX_PRBS_EN
module adc_tx_lfsr8
  import adc_stream_tx_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic              adv_i,
  output logic [PRBS_W-1:0] q_o
);

  logic [PRBS_W-1:0] lfsr_q;
  logic [PRBS_W-1:0] lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (load_i) begin
      lfsr_d = PRBS_SEED;
    end else if (adv_i) begin
      lfsr_d = prbs_next(lfsr_q);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr_q <= PRBS_SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign q_o = lfsr_q;

endmodule
`endif

// File: rtl/adc_stream_tx.sv
// ADC sample stream transmitter: ramp/triangle/constant/PRBS samples at a programmable rate.
// Define ADC_STREAM_TX_PRBS_EN to make mode 3 a PRBS; without it mode 3 is a ramp.
module adc_stream_tx
  import adc_stream_tx_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned CNT_W  = 16,
  parameter int unsigned DIV_W  = 8
) (
  input  logic              clk_pin_p,
  input  logic              rst_pin,
  input  logic              start_i,
  input  logic              stop_i,
  input  logic [1:0]        mode_i,
  input  logic [DIV_W-1:0]  rate_div_i,
  input  logic [CNT_W-1:0]  burst_len_i,
  input  logic [DATA_W-1:0] const_i,
  input  logic              adc_ready_i,
  output logic [DATA_W-1:0] adc_data_o,
  output logic              adc_valid_o,
  output logic              busy_o,
  output logic              done_o,
  output logic [CNT_W-1:0]  sample_cnt_o,
  output logic              overrun_o
);

  state_e            state_q, state_d;
  mode_e             mode_q, mode_d;
  logic [DIV_W-1:0]  rate_q, rate_d;
  logic [CNT_W-1:0]  burst_q, burst_d;
  logic [DATA_W-1:0] const_q, const_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [CNT_W-1:0]  issued_q, issued_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ovr_q, ovr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [DATA_W-1:0] ramp_q, ramp_d;
  logic [DATA_W-1:0] tri_q, tri_d;
  logic              tri_up_q, tri_up_d;

  logic              begin_run;
  logic              hs;
  logic              tick;
  logic              load;
  logic              last;
  logic [DATA_W-1:0] gen_sample;

`ifdef ADC_STREAM_TX_PRBS_EN
  logic [PRBS_W-1:0] prbs_val;

  adc_tx_lfsr8 u_lfsr (
    .clk    (clk_pin_p),
    .rst    (rst_pin),
    .load_i (begin_run),
    .adv_i  (load),
    .q_o    (prbs_val)
  );
`endif

  // Handshake, rate tick and sample-load qualifiers
  always_comb begin
    begin_run = (state_q == IDLE) && start_i && !stop_i;
    hs        = valid_q && adc_ready_i;
    tick      = (state_q == RUN) && (div_q == '0);
    load      = tick && (!valid_q || adc_ready_i);
    last      = load && (burst_q != '0) && ((issued_q + CNT_W'(1)) == burst_q);
  end

  // Sample source selected by the latched mode
  always_comb begin
    gen_sample = ramp_q;
    case (mode_q)
      MODE_TRI:   gen_sample = tri_q;
      MODE_CONST: gen_sample = const_q;
`ifdef ADC_STREAM_TX_PRBS_EN
      MODE_PRBS:  gen_sample = DATA_W'(prbs_val);
`endif
      default:    gen_sample = ramp_q;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    rate_d   = rate_q;
    burst_d  = burst_q;
    const_d  = const_q;
    div_d    = div_q;
    issued_d = issued_q;
    cnt_d    = cnt_q;
    ovr_d    = ovr_q;
    data_d   = data_q;
    valid_d  = valid_q;
    ramp_d   = ramp_q;
    tri_d    = tri_q;
    tri_up_d = tri_up_q;

    case (state_q)
      IDLE: begin
        if (begin_run) begin
          state_d  = RUN;
          mode_d   = mode_e'(mode_i);
          rate_d   = rate_div_i;
          burst_d  = burst_len_i;
          const_d  = const_i;
          div_d    = '0;
          issued_d = '0;
          cnt_d    = '0;
          ovr_d    = 1'b0;
          ramp_d   = '0;
          tri_d    = '0;
          tri_up_d = 1'b1;
        end
      end
      RUN: begin
        div_d = (div_q == rate_q) ? '0 : div_q + DIV_W'(1);
        if (stop_i || last) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (!valid_q || adc_ready_i) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // A tick that finds the previous sample still waiting is dropped and flagged
    if (tick && valid_q && !adc_ready_i) begin
      ovr_d = 1'b1;
    end

    if (hs && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    if (load) begin
      data_d   = gen_sample;
      valid_d  = 1'b1;
      issued_d = issued_q + CNT_W'(1);
      ramp_d   = ramp_q + DATA_W'(1);
      if (tri_up_q) begin
        if (tri_q == '1) begin
          tri_d    = tri_q - DATA_W'(1);
          tri_up_d = 1'b0;
        end else begin
          tri_d = tri_q + DATA_W'(1);
        end
      end else begin
        if (tri_q == '0) begin
          tri_d    = DATA_W'(1);
          tri_up_d = 1'b1;
        end else begin
          tri_d = tri_q - DATA_W'(1);
        end
      end
    end else if (hs) begin
      valid_d = 1'b0;
    end

    busy_d = (state_d == RUN) || (state_d == DRAIN);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk_pin_p or posedge rst_pin) begin
    if (rst_pin) begin
      state_q  <= IDLE;
      mode_q   <= MODE_RAMP;
      rate_q   <= '0;
      burst_q  <= '0;
      const_q  <= '0;
      div_q    <= '0;
      issued_q <= '0;
      cnt_q    <= '0;
      ovr_q    <= 1'b0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      ramp_q   <= '0;
      tri_q    <= '0;
      tri_up_q <= 1'b1;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      rate_q   <= rate_d;
      burst_q  <= burst_d;
      const_q  <= const_d;
      div_q    <= div_d;
      issued_q <= issued_d;
      cnt_q    <= cnt_d;
      ovr_q    <= ovr_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      ramp_q   <= ramp_d;
      tri_q    <= tri_d;
      tri_up_q <= tri_up_d;
    end
  end

  assign adc_data_o   = data_q;
  assign adc_valid_o  = valid_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign sample_cnt_o = cnt_q;
  assign overrun_o    = ovr_q;

endmodule

// File: tb/tb_adc_stream_tx.sv
// Self-checking bench for adc_stream_tx: vector table of stream configurations plus
// hand-written overrun, reset and start/stop corner sequences, with a data scoreboard.
module tb_adc_stream_tx;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_i = 1'b0;
  logic        stop_i = 1'b0;
  logic [1:0]  mode_i = 2'd0;
  logic [7:0]  rate_div_i = 8'd0;
  logic [15:0] burst_len_i = 16'd0;
  logic [7:0]  const_i = 8'd0;
  logic        adc_ready_i = 1'b0;
  logic [7:0]  adc_data_o;
  logic        adc_valid_o;
  logic        busy_o;
  logic        done_o;
  logic [15:0] sample_cnt_o;
  logic        overrun_o;

  adc_stream_tx dut (
    .clk_pin_p    (clk),
    .rst_pin      (rst),
    .start_i      (start_i),
    .stop_i       (stop_i),
    .mode_i       (mode_i),
    .rate_div_i   (rate_div_i),
    .burst_len_i  (burst_len_i),
    .const_i      (const_i),
    .adc_ready_i  (adc_ready_i),
    .adc_data_o   (adc_data_o),
    .adc_valid_o  (adc_valid_o),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .sample_cnt_o (sample_cnt_o),
    .overrun_o    (overrun_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  mode;
    logic [7:0]  rate;
    logic [15:0] burst;
    logic [7:0]  cval;
    int          n;
  } vec_t;

  vec_t       vecs[5];
  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_q[$];
  int         cyc = 0;
  int         hs_cnt = 0;
  int         last_hs_cyc = 0;
  int         gap_exp = 1;
  bit         mon_en = 1'b0;
  bit         gap_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: every accepted sample is matched against the next expected value
  always @(negedge clk) begin
    if (mon_en && adc_valid_o && adc_ready_i) begin
      hs_cnt++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_underflow: got %0h with no expected sample at %0t", adc_data_o, $time);
      end else begin
        chk("sb_data", 32'(adc_data_o), 32'(exp_q.pop_front()));
      end
      if (gap_en && hs_cnt > 1) chk("rate_gap", 32'(cyc - last_hs_cyc), 32'(gap_exp));
      last_hs_cyc = cyc;
    end
  end

  // Reference sample sequences derived from the generator definitions
  task automatic push_seq(input logic [1:0] mode, input logic [7:0] cval, input int count);
    logic [7:0] r;
    logic [7:0] t;
    logic [7:0] s;
    bit         up;
    r = 8'h00; t = 8'h00; s = 8'hFF; up = 1'b1;
    exp_q.delete();
    for (int i = 0; i < count; i++) begin
      case (mode)
        2'd1: begin
          exp_q.push_back(t);
          if (up) begin
            if (t == 8'hFF) begin t = 8'hFE; up = 1'b0; end
            else t = t + 8'd1;
          end else begin
            if (t == 8'h00) begin t = 8'h01; up = 1'b1; end
            else t = t - 8'd1;
          end
        end
        2'd2: exp_q.push_back(cval);
`ifdef ADC_STREAM_TX_PRBS_EN
        2'd3: begin
          exp_q.push_back(s);
          s = {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
        end
`endif
        default: begin
          exp_q.push_back(r);
          r = r + 8'd1;
        end
      endcase
    end
  endtask

  task automatic wait_done();
    int i;
    i = 0;
    while (!done_o && i < 5000) begin
      @(negedge clk);
      i++;
    end
    chk("done_pulse", 32'(done_o), 32'd1);
    chk("busy_in_done", 32'(busy_o), 32'd0);
    @(negedge clk);
    chk("done_one_cycle", 32'(done_o), 32'd0);
    chk("idle_valid", 32'(adc_valid_o), 32'd0);
  endtask

  task automatic stop_after(input int n);
    for (int i = 0; i < 5000 && hs_cnt < n; i++) @(posedge clk);
    chk("hs_reached", 32'(hs_cnt >= n), 32'd1);
    #1 stop_i = 1'b1;
    @(posedge clk);
    #1 stop_i = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    int exp_cnt;
    push_seq(v.mode, v.cval, v.n + 8);
    hs_cnt  = 0;
    gap_exp = int'(v.rate) + 1;
    gap_en  = 1'b1;
    mon_en  = 1'b1;
    @(posedge clk);
    #1;
    mode_i = v.mode; rate_div_i = v.rate; burst_len_i = v.burst; const_i = v.cval;
    adc_ready_i = 1'b1; start_i = 1'b1;
    @(posedge clk);
    #1 start_i = 1'b0;
    chk("latency_edge_n_valid", 32'(adc_valid_o), 32'd0);
    chk("latency_edge_n_busy", 32'(busy_o), 32'd1);
    @(posedge clk);
    #1 chk("latency_edge_n1_valid", 32'(adc_valid_o), 32'd1);
    if (v.burst == 16'd0) stop_after(v.n);
    wait_done();
    exp_cnt = (v.burst != 16'd0) ? int'(v.burst) : hs_cnt;
    if (v.burst != 16'd0) chk("burst_accepted", 32'(hs_cnt), 32'(v.burst));
    chk("sample_cnt", 32'(sample_cnt_o), 32'(exp_cnt));
    chk("overrun_clear", 32'(overrun_o), 32'd0);
    mon_en = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish at %0t", $time);
    $fatal(1);
  end

  initial begin
    vecs[0] = '{mode: 2'd0, rate: 8'd0, burst: 16'd4,   cval: 8'h00, n: 4};
    vecs[1] = '{mode: 2'd1, rate: 8'd0, burst: 16'd0,   cval: 8'h00, n: 520};
    vecs[2] = '{mode: 2'd2, rate: 8'd3, burst: 16'd0,   cval: 8'hA5, n: 5};
    vecs[3] = '{mode: 2'd3, rate: 8'd0, burst: 16'd300, cval: 8'h00, n: 300};
    vecs[4] = '{mode: 2'd0, rate: 8'd2, burst: 16'd3,   cval: 8'h00, n: 3};

    repeat (2) @(posedge clk);
    #1;
    chk("rst_data", 32'(adc_data_o), 32'd0);
    chk("rst_valid", 32'(adc_valid_o), 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_done", 32'(done_o), 32'd0);
    chk("rst_cnt", 32'(sample_cnt_o), 32'd0);
    chk("rst_overrun", 32'(overrun_o), 32'd0);
    rst = 1'b0;

    // Sink stalls: sample held, overrun flagged, no sample skipped afterwards
    push_seq(2'd0, 8'h00, 20);
    hs_cnt = 0; gap_en = 1'b0; mon_en = 1'b1;
    @(posedge clk);
    #1 mode_i = 2'd0; rate_div_i = 8'd0; burst_len_i = 16'd0; adc_ready_i = 1'b0; start_i = 1'b1;
    @(posedge clk);
    #1 start_i = 1'b0;
    @(posedge clk);
    repeat (5) begin
      @(posedge clk);
      #1;
      chk("stall_data", 32'(adc_data_o), 32'h00);
      chk("stall_valid", 32'(adc_valid_o), 32'd1);
    end
    chk("overrun_set", 32'(overrun_o), 32'd1);
    adc_ready_i = 1'b1;
    stop_after(3);
    wait_done();
    chk("overrun_sticky", 32'(overrun_o), 32'd1);
    mon_en = 1'b0;

    for (int i = 0; i < 5; i++) run_vec(vecs[i]);

    // Reset in the middle of a burst drops valid/busy without waiting for a clock edge
    push_seq(2'd0, 8'h00, 120);
    hs_cnt = 0; gap_exp = 1; gap_en = 1'b1; mon_en = 1'b1;
    @(posedge clk);
    #1 mode_i = 2'd0; rate_div_i = 8'd0; burst_len_i = 16'd100; adc_ready_i = 1'b1; start_i = 1'b1;
    @(posedge clk);
    #1 start_i = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("pre_rst_valid", 32'(adc_valid_o), 32'd1);
    #1 mon_en = 1'b0;
    rst = 1'b1;
    #1;
    chk("async_rst_valid", 32'(adc_valid_o), 32'd0);
    chk("async_rst_busy", 32'(busy_o), 32'd0);
    chk("async_rst_cnt", 32'(sample_cnt_o), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Start and stop together in IDLE: nothing happens
    @(posedge clk);
    #1 start_i = 1'b1; stop_i = 1'b1;
    @(posedge clk);
    #1 start_i = 1'b0; stop_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("startstop_busy", 32'(busy_o), 32'd0);
      chk("startstop_valid", 32'(adc_valid_o), 32'd0);
      chk("startstop_done", 32'(done_o), 32'd0);
      @(posedge clk);
      #1;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
